// File: rtl/channel_mux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// channel_mux_pkg : mode encodings and width helper for channel_scan_mux
// Rev 1.0
// ---------------------------------------------------------------------------
package channel_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int width_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_tick_gen : dwell divider, flags the terminal count of each scan dwell
// Rev 1.0
// ---------------------------------------------------------------------------
module scan_tick_gen
  import channel_mux_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = width_for(SCAN_DIV);
  localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  // Combinational so the parent can advance the channel on this same edge.
  assign tick = en && !clr && (cnt == TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clr || (cnt == TC)) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/channel_scan_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// channel_scan_mux : registered N-channel mux with manual select or timed scan
// Rev 1.0
// ---------------------------------------------------------------------------
module channel_scan_mux
  import channel_mux_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int NCH      = 4,
  parameter  int SCAN_DIV = 100000,
  localparam int SELW     = width_for(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*WIDTH-1:0]  din,
  input  logic [SELW-1:0]       sel,
  input  logic                  mode,
  input  logic                  en,
  output logic [WIDTH-1:0]      z,
  output logic [SELW-1:0]       ch,
  output logic [NCH-1:0]        onehot,
  output logic                  tick
);

  localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

  logic             adv;
  logic [SELW-1:0]  ch_base;
  logic [SELW-1:0]  ch_next;
  logic [WIDTH-1:0] z_next;
  logic [NCH-1:0]   onehot_next;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (mode == MODE_MANUAL),
    .en   (en),
    .tick (adv)
  );

  // An out-of-range manual index restarts scanning from channel 0.
  assign ch_base = ({1'b0, ch} >= NCH_W) ? '0 : ch;

  always_comb begin
    ch_next = ch_base;
    if (mode == MODE_MANUAL) begin
      ch_next = sel;
    end else if (adv) begin
      ch_next = ({1'b0, ch} >= (NCH_W - 1'b1)) ? '0 : ch + 1'b1;
    end

    z_next      = '0;
    onehot_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_next == SELW'(i)) begin
        z_next         = din[i*WIDTH +: WIDTH];
        onehot_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z      <= '0;
      ch     <= '0;
      onehot <= NCH'(1);
      tick   <= 1'b0;
    end else begin
      tick <= adv;
      if (en) begin
        z      <= z_next;
        ch     <= ch_next;
        onehot <= onehot_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/channel_scan_mux.md
CHANNEL_SCAN_MUX -- requirements
Module: channel_scan_mux

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter WIDTH, default 4: bits per channel, minimum 1.
REQ-003 Parameter NCH, default 4: number of input channels, minimum 2.
REQ-004 Parameter SCAN_DIV, default 100000: clocks per channel in scan mode, minimum 1.
REQ-005 Derived constant SELW SHALL be max(1, clog2(NCH)).
REQ-006 Port clk, input, 1: system clock, rising edge.
REQ-007 Port rst, input, 1: asynchronous active-high reset.
REQ-008 Port din, input, NCH*WIDTH: flat channel bus; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port sel, input, SELW: channel select in manual mode.
REQ-010 Port mode, input, 1: 0 = manual, 1 = scan.
REQ-011 Port en, input, 1: clock enable; 0 freezes all state.
REQ-012 Port z, output, WIDTH: registered selected channel data.
REQ-013 Port ch, output, SELW: registered index of the channel currently driven on z.
REQ-014 Port onehot, output, NCH: registered one-hot decode of ch; used as the 7-seg anode/scan strobe.
REQ-015 Port tick, output, 1: one-cycle pulse asserted in the cycle ch advances in scan mode.

Function
REQ-016 All outputs SHALL be registered. ch_next is the index computed below, and z, ch and onehot SHALL update together from ch_next on each clk edge with en=1.
REQ-017 z SHALL equal din[ch_next] sampled at that edge. Latency from din or sel to z SHALL be exactly 1 clock.
REQ-018 If ch_next >= NCH (possible when NCH is not a power of 2), z SHALL be 0 and onehot SHALL be all zeros; ch SHALL still hold ch_next.
REQ-019 Manual mode: ch_next = sel. The scan divider SHALL be held at 0 and tick SHALL be 0.
REQ-020 Scan mode: the divider SHALL count 0..SCAN_DIV-1 once per enabled clock.
REQ-021 Scan mode, divider at terminal count: ch_next = ch+1, wrapping from NCH-1 to 0; the divider returns to 0 and tick is 1 for that cycle.
REQ-022 Scan mode, divider not at terminal count: ch_next = ch.
REQ-023 In scan mode z SHALL track din changes on the current channel with 1-cycle latency, independent of tick.
REQ-024 SCAN_DIV=1: ch SHALL advance on every enabled clock and tick SHALL be held at 1.
REQ-025 Manual-to-scan switch: scanning SHALL start from the current ch (from 0 if ch >= NCH), with the divider at 0. The first advance SHALL occur SCAN_DIV enabled clocks later.
REQ-026 Scan-to-manual switch: sel SHALL take effect on the first edge with mode=0, and the divider SHALL be cleared on that edge.
REQ-027 en=0: z, ch, onehot and the divider SHALL hold, and tick SHALL be 0. Resuming SHALL continue the count from where it stopped.
REQ-028 The divider width SHALL be max(1, clog2(SCAN_DIV)) and SHALL never exceed SCAN_DIV-1.

Reset
REQ-029 While rst=1, independent of clk: z=0, ch=0, onehot=1 (bit 0 set), tick=0, divider=0.
REQ-030 After rst deasserts, z SHALL remain 0 until the first enabled edge.
REQ-031 rst mid-scan SHALL abort the current dwell. Scanning SHALL restart at channel 0 with a full SCAN_DIV dwell.

Structure
REQ-032 Package channel_mux_pkg SHALL hold the mode encoding constants (MODE_MANUAL=0, MODE_SCAN=1) and a clog2-based width helper.
REQ-033 The divider SHALL be a sub-module scan_tick_gen (parameter SCAN_DIV; ports clk, rst, clr, en, tick).
REQ-034 Channel selection and decode SHALL be parametrised loops over NCH, with no per-channel instances.

Verification
REQ-035 Manual, WIDTH=4, NCH=4: din channels 0..3 = 0xC, 0x5, 0xA, 0x3; sel 0,1,2,3 on consecutive clocks -> z = C,5,A,3 and onehot = 0001,0010,0100,1000, each one clock after sel.
REQ-036 NCH=3, manual: sel=3 -> z=0, onehot=000, ch=3; then sel=2 -> z=din[2] next clock.
REQ-037 Scan, SCAN_DIV=4, NCH=4: ch sequence 0,1,2,3,0 with 4 clocks per channel; tick high for 1 clock exactly at each advance; 3->0 wrap observed.
REQ-038 Scan with en toggled low for 3 clocks mid-dwell -> ch and divider frozen; the next advance is delayed by exactly 3 clocks.
REQ-039 Async rst asserted between clk edges during scan at ch=2 -> z=0, ch=0, onehot=0001 immediately; after release, first advance 4 enabled clocks later.
REQ-040 SCAN_DIV=1, NCH=4 -> ch advances every enabled clock and tick stays 1; mode switch to manual with sel=1 -> ch=1 and tick=0 on the next edge.
